// File: rtl/surf4_hk_pkg.sv
// rtl/surf4_hk_pkg.sv - register map, FSM encoding and status bit positions for the housekeeping scanner
package surf4_hk_pkg;

    localparam logic [6:0] REG_CTRL    = 7'h00;
    localparam logic [6:0] REG_STATUS  = 7'h01;
    localparam logic [6:0] REG_NCH     = 7'h02;
    localparam logic [6:0] CHADDR_BASE = 7'h20;
    localparam logic [6:0] RESULT_BASE = 7'h40;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MODE = 1;
    localparam int CTRL_SS   = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_TIMEOUT = 1;
    localparam int STAT_OVERRUN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_STORE,
        ST_NEXT
    } hk_state_e;

endpackage

// File: rtl/surf4_hk_drp_seq.sv
// rtl/surf4_hk_drp_seq.sv - scan FSM, DRDY timeout counter and DRP read port
module surf4_hk_drp_seq #(
    parameter int DRP_AW  = 7,
    parameter int DRP_DW  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [4:0]        nch_i,
    input  logic [DRP_AW-1:0] chaddr_i,
    input  logic [DRP_DW-1:0] drp_do_i,
    input  logic              drp_drdy_i,
    output logic              busy_o,
    output logic [4:0]        idx_o,
    output logic              store_o,
    output logic [15:0]       value_o,
    output logic              timeout_o,
    output logic              scan_done_o,
    output logic              drp_den_o,
    output logic [DRP_AW-1:0] drp_daddr_o
);
    import surf4_hk_pkg::*;

    localparam int TW = $clog2(TIMEOUT + 1);

    hk_state_e     state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [15:0]   value_q, value_d;
    logic          unused_do;

    assign unused_do = ^drp_do_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            value_q <= value_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        value_d     = value_q;
        timeout_o   = 1'b0;
        scan_done_o = 1'b0;
        store_o     = 1'b0;
        drp_den_o   = 1'b0;
        drp_daddr_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    idx_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                drp_den_o   = 1'b1;
                drp_daddr_o = chaddr_i;
                timer_d     = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // DRDY is checked first so a response on the final timer cycle still lands
                if (drp_drdy_i) begin
                    value_d = 16'(drp_do_i);
                    state_d = ST_STORE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    value_d   = 16'hFFFF;
                    timeout_o = 1'b1;
                    state_d   = ST_STORE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_STORE: begin
                store_o = 1'b1;
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (idx_q >= nch_i) begin
                    scan_done_o = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign idx_o   = idx_q;
    assign value_o = value_q;

endmodule

// File: rtl/surf4_hk_scanner.sv
// rtl/surf4_hk_scanner.sv - WISHBONE register bank and result store around the DRP scan sequencer
module surf4_hk_scanner #(
    parameter int NUM_CH  = 8,
    parameter int DRP_AW  = 7,
    parameter int DRP_DW  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [8:0]        wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    input  logic              pps_i,
    output logic              drp_den_o,
    output logic              drp_dwe_o,
    output logic [DRP_AW-1:0] drp_daddr_o,
    output logic [DRP_DW-1:0] drp_di_o,
    input  logic [DRP_DW-1:0] drp_do_i,
    input  logic              drp_drdy_i,
    output logic              scan_done_o
);
    import surf4_hk_pkg::*;

    localparam logic [4:0] NCH_MAX = 5'(NUM_CH - 1);

    function automatic logic [NUM_CH-1:0][DRP_AW-1:0] chaddr_init();
        logic [NUM_CH-1:0][DRP_AW-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = DRP_AW'(i);
        return v;
    endfunction

    logic                          ctrl_en_q, ctrl_en_d, ctrl_mode_q, ctrl_mode_d;
    logic                          tmo_err_q, tmo_err_d, pps_ovr_q, pps_ovr_d;
    logic [15:0]                   scan_count_q, scan_count_d;
    logic [4:0]                    nch_q, nch_d;
    logic [NUM_CH-1:0][DRP_AW-1:0] chaddr_q, chaddr_d;
    logic [NUM_CH-1:0][31:0]       result_q, result_d;
    logic                          ack_q, ack_d, pps_q, pps_d;
    logic [31:0]                   dat_q, dat_d, rd_data;

    logic [6:0]        word;
    logic              req, wr, pps_rise, ss_wr, start;
    logic              seq_busy, seq_store, seq_timeout, seq_done;
    logic [4:0]        seq_idx;
    logic [15:0]       seq_value;
    logic [DRP_AW-1:0] cur_chaddr;
    logic              unused_ok;

    assign word      = wbs_adr_i[8:2];
    assign req       = wbs_cyc_i & wbs_stb_i & ~ack_q;
    assign wr        = req & wbs_we_i;
    assign pps_rise  = pps_i & ~pps_q;
    assign ss_wr     = wr && (word == REG_CTRL) && wbs_dat_i[CTRL_SS];
    assign start     = (ctrl_en_q & ~ctrl_mode_q) | (ctrl_en_q & ctrl_mode_q & pps_rise) | ss_wr;
    assign unused_ok = ^{wbs_adr_i[1:0], wbs_dat_i};

    always_comb begin
        cur_chaddr = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (seq_idx == 5'(i)) cur_chaddr = chaddr_q[i];
        end
    end

    surf4_hk_drp_seq #(
        .DRP_AW  (DRP_AW),
        .DRP_DW  (DRP_DW),
        .TIMEOUT (TIMEOUT)
    ) u_seq (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start),
        .nch_i       (nch_q),
        .chaddr_i    (cur_chaddr),
        .drp_do_i    (drp_do_i),
        .drp_drdy_i  (drp_drdy_i),
        .busy_o      (seq_busy),
        .idx_o       (seq_idx),
        .store_o     (seq_store),
        .value_o     (seq_value),
        .timeout_o   (seq_timeout),
        .scan_done_o (seq_done),
        .drp_den_o   (drp_den_o),
        .drp_daddr_o (drp_daddr_o)
    );

    always_comb begin
        rd_data = '0;
        case (word)
            REG_CTRL:   rd_data = {29'd0, 1'b0, ctrl_mode_q, ctrl_en_q};
            REG_STATUS: rd_data = {scan_count_q, 13'd0, pps_ovr_q, tmo_err_q, seq_busy};
            REG_NCH:    rd_data = {27'd0, nch_q};
            default:    rd_data = '0;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (word == CHADDR_BASE + 7'(i)) rd_data = 32'(chaddr_q[i]);
            if (word == RESULT_BASE + 7'(i)) rd_data = result_q[i];
        end
    end

    always_comb begin
        ctrl_en_d    = ctrl_en_q;
        ctrl_mode_d  = ctrl_mode_q;
        tmo_err_d    = tmo_err_q;
        pps_ovr_d    = pps_ovr_q;
        scan_count_d = scan_count_q;
        nch_d        = nch_q;
        chaddr_d     = chaddr_q;
        result_d     = result_q;
        pps_d        = pps_i;
        ack_d        = req;
        dat_d        = req ? rd_data : 32'd0;

        if (wr) begin
            if (word == REG_CTRL) begin
                ctrl_en_d   = wbs_dat_i[CTRL_EN];
                ctrl_mode_d = wbs_dat_i[CTRL_MODE];
            end
            if (word == REG_STATUS) begin
                if (wbs_dat_i[STAT_TIMEOUT]) tmo_err_d = 1'b0;
                if (wbs_dat_i[STAT_OVERRUN]) pps_ovr_d = 1'b0;
            end
            if (word == REG_NCH) nch_d = (wbs_dat_i[4:0] > NCH_MAX) ? NCH_MAX : wbs_dat_i[4:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (word == CHADDR_BASE + 7'(i)) chaddr_d[i] = wbs_dat_i[DRP_AW-1:0];
            end
        end

        // sticky sets come after the W1C clears so a coincident event is not lost
        if (seq_timeout) tmo_err_d = 1'b1;
        if (pps_rise && ctrl_en_q && ctrl_mode_q && seq_busy) pps_ovr_d = 1'b1;
        if (seq_done) scan_count_d = scan_count_q + 16'd1;
        if (seq_store) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (seq_idx == 5'(i)) result_d[i] = {scan_count_q, seq_value};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_en_q    <= 1'b0;
            ctrl_mode_q  <= 1'b0;
            tmo_err_q    <= 1'b0;
            pps_ovr_q    <= 1'b0;
            scan_count_q <= '0;
            nch_q        <= NCH_MAX;
            chaddr_q     <= chaddr_init();
            result_q     <= '0;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            pps_q        <= 1'b0;
        end else begin
            ctrl_en_q    <= ctrl_en_d;
            ctrl_mode_q  <= ctrl_mode_d;
            tmo_err_q    <= tmo_err_d;
            pps_ovr_q    <= pps_ovr_d;
            scan_count_q <= scan_count_d;
            nch_q        <= nch_d;
            chaddr_q     <= chaddr_d;
            result_q     <= result_d;
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            pps_q        <= pps_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign drp_dwe_o   = 1'b0;
    assign drp_di_o    = '0;
    assign scan_done_o = seq_done;

endmodule

// File: tb/tb_surf4_hk_scanner.sv
// tb/tb_surf4_hk_scanner.sv - directed vector bench for the housekeeping scanner with a simple DRP responder
module tb_surf4_hk_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc, wbs_stb, wbs_we;
    logic [8:0]  wbs_adr;
    logic [31:0] wbs_dat_i, wbs_dat_o;
    logic        wbs_ack;
    logic        pps;
    logic        drp_den, drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = 16'h0;
    logic        drp_drdy = 1'b0;
    logic        scan_done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    surf4_hk_scanner #(
        .NUM_CH  (8),
        .DRP_AW  (7),
        .DRP_DW  (16),
        .TIMEOUT (255)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wbs_cyc_i   (wbs_cyc),
        .wbs_stb_i   (wbs_stb),
        .wbs_we_i    (wbs_we),
        .wbs_adr_i   (wbs_adr),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_dat_o   (wbs_dat_o),
        .wbs_ack_o   (wbs_ack),
        .pps_i       (pps),
        .drp_den_o   (drp_den),
        .drp_dwe_o   (drp_dwe),
        .drp_daddr_o (drp_daddr),
        .drp_di_o    (drp_di),
        .drp_do_i    (drp_do),
        .drp_drdy_i  (drp_drdy),
        .scan_done_o (scan_done)
    );

    // DRP responder: answers addr<<4 three cycles after den unless the address is stalled
    int         den_count = 0;
    int         done_count = 0;
    int         dwe_seen = 0;
    int         pend = 0;
    logic [6:0] pend_addr = 7'h0;
    logic       stall_en = 1'b0;
    logic [6:0] stall_addr = 7'h0;
    logic [6:0] den_log[$];

    always @(posedge clk) begin
        #1;
        drp_drdy = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                drp_drdy = 1'b1;
                drp_do   = {5'b0, pend_addr, 4'b0};
            end
        end
        if (drp_den) begin
            den_count++;
            den_log.push_back(drp_daddr);
            if (!(stall_en && drp_daddr == stall_addr)) begin
                pend      = 3;
                pend_addr = drp_daddr;
            end
        end
        if (scan_done) done_count++;
        if (drp_dwe || drp_di != 16'h0) dwe_seen++;
    end

    function automatic logic [31:0] get_log(input int i);
        if (i < den_log.size()) return 32'(den_log[i]);
        return 32'hDEAD;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic wb(input logic we, input logic [6:0] w, input logic [31:0] d, output logic [31:0] q);
        int n;
        @(negedge clk);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we;
        wbs_adr = {w, 2'b00}; wbs_dat_i = d;
        n = 0;
        q = 32'h0;
        do begin
            @(negedge clk);
            n++;
        end while (!wbs_ack && n < 8);
        if (!wbs_ack) begin
            checks++;
            failures++;
            $display("FAIL wb_ack word=%h got=0 expected=1", w);
        end else begin
            q = wbs_dat_o;
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    endtask

    task automatic wr(input logic [6:0] w, input logic [31:0] d);
        logic [31:0] q;
        wb(1'b1, w, d, q);
    endtask

    task automatic rd_chk(input string name, input logic [6:0] w, input logic [31:0] exp);
        logic [31:0] q;
        wb(1'b0, w, 32'h0, q);
        chk(name, q, exp);
    endtask

    task automatic pulse_pps();
        @(negedge clk); pps = 1'b1;
        @(negedge clk); pps = 1'b0;
    endtask

    task automatic wait_done(input int target, input int bound);
        int n = 0;
        while (done_count < target && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_den(input int target, input int bound);
        int n = 0;
        while (den_count < target && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [6:0]  w;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[22];

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_den;
        tbl[0]  = '{1'b0, 7'h23, 32'h0,        32'h3};
        tbl[1]  = '{1'b0, 7'h02, 32'h0,        32'h7};
        tbl[2]  = '{1'b0, 7'h00, 32'h0,        32'h0};
        tbl[3]  = '{1'b0, 7'h01, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, 7'h40, 32'h0,        32'h0};
        tbl[5]  = '{1'b1, 7'h02, 32'h1F,       32'h0};
        tbl[6]  = '{1'b0, 7'h02, 32'h0,        32'h7};
        tbl[7]  = '{1'b1, 7'h02, 32'h3,        32'h0};
        tbl[8]  = '{1'b0, 7'h02, 32'h0,        32'h3};
        tbl[9]  = '{1'b1, 7'h27, 32'hFFFF,     32'h0};
        tbl[10] = '{1'b0, 7'h27, 32'h0,        32'h7F};
        tbl[11] = '{1'b1, 7'h28, 32'h55,       32'h0};
        tbl[12] = '{1'b0, 7'h28, 32'h0,        32'h0};
        tbl[13] = '{1'b1, 7'h10, 32'h1234,     32'h0};
        tbl[14] = '{1'b0, 7'h10, 32'h0,        32'h0};
        tbl[15] = '{1'b1, 7'h00, 32'h2,        32'h0};
        tbl[16] = '{1'b0, 7'h00, 32'h0,        32'h2};
        tbl[17] = '{1'b1, 7'h00, 32'h0,        32'h0};
        tbl[18] = '{1'b1, 7'h41, 32'hDEAD,     32'h0};
        tbl[19] = '{1'b0, 7'h41, 32'h0,        32'h0};
        tbl[20] = '{1'b1, 7'h01, 32'hFFFFFFFF, 32'h0};
        tbl[21] = '{1'b0, 7'h01, 32'h0,        32'h0};

        rst = 1'b1; pps = 1'b0;
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0; wbs_adr = '0; wbs_dat_i = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {28'h0, drp_den, wbs_ack, scan_done, drp_dwe}, 32'h0);
        chk("reset_daddr", 32'(drp_daddr), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            logic [31:0] q;
            wb(tbl[i].we, tbl[i].w, tbl[i].d, q);
            if (!tbl[i].we) chk($sformatf("vec%0d", i), q, tbl[i].exp);
        end
        chk("no_den_after_reset", den_count, 0);

        // single-shot over three channels
        wr(7'h02, 32'h2);
        wr(7'h20, 32'h00);
        wr(7'h21, 32'h01);
        wr(7'h22, 32'h06);
        wr(7'h00, 32'h4);
        wait_done(1, 200);
        chk("ss_done", done_count, 1);
        chk("ss_den_count", den_count, 3);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] exp_addr;
            exp_addr = (i == 2) ? 32'h6 : 32'(i);
            chk($sformatf("ss_den_addr%0d", i), get_log(i), exp_addr);
        end
        rd_chk("ss_res0", 7'h40, 32'h00000000);
        rd_chk("ss_res1", 7'h41, 32'h00000010);
        rd_chk("ss_res2", 7'h42, 32'h00000060);
        rd_chk("ss_status", 7'h01, 32'h00010000);
        rd_chk("ss_ctrl_selfclear", 7'h00, 32'h0);
        repeat (50) @(negedge clk);
        chk("ss_no_restart", den_count, 3);

        // PPS mode: one scan per pulse, tag follows scan_count
        wr(7'h00, 32'h3);
        for (int j = 1; j <= 3; j++) begin
            pulse_pps();
            repeat (1000) @(negedge clk);
            chk($sformatf("pps%0d_done", j), done_count, 1 + j);
            rd_chk($sformatf("pps%0d_res2", j), 7'h42, {16'(j), 16'h0060});
            rd_chk($sformatf("pps%0d_status", j), 7'h01, {16'(j + 1), 16'h0000});
        end

        // stalled channel times out; a PPS edge during the stall flags overrun
        stall_addr = 7'h01;
        stall_en = 1'b1;
        pulse_pps();
        repeat (40) @(negedge clk);
        pulse_pps();
        wait_done(5, 600);
        repeat (50) @(negedge clk);
        chk("tmo_done", done_count, 5);
        stall_en = 1'b0;
        rd_chk("tmo_res0", 7'h40, 32'h00040000);
        rd_chk("tmo_res1", 7'h41, 32'h0004FFFF);
        rd_chk("tmo_res2", 7'h42, 32'h00040060);
        rd_chk("tmo_status", 7'h01, 32'h00050006);
        wr(7'h01, 32'h6);
        rd_chk("w1c_status", 7'h01, 32'h00050000);

        // continuous mode, disabled mid-scan: current scan completes, then stops
        base_den = den_count;
        wr(7'h00, 32'h1);
        wait_den(base_den + 2, 100);
        wr(7'h00, 32'h0);
        repeat (100) @(negedge clk);
        chk("cont_den", den_count, base_den + 3);
        chk("cont_done", done_count, 6);
        rd_chk("cont_status", 7'h01, 32'h00060000);

        // reset while waiting on DRDY; the late DRDY must be ignored
        base_den = den_count;
        wr(7'h00, 32'h4);
        wait_den(base_den + 1, 50);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("rst_den", den_count, base_den + 1);
        chk("rst_done", done_count, 6);
        rd_chk("rst_status", 7'h01, 32'h0);
        rd_chk("rst_res0", 7'h40, 32'h0);
        rd_chk("rst_res1", 7'h41, 32'h0);
        rd_chk("rst_chaddr2", 7'h22, 32'h2);
        rd_chk("rst_nch", 7'h02, 32'h7);
        chk("dwe_never", dwe_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
